alu_share_arb: RTL and testbench



---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_4bit.sv | 41 ++++
 rtl/alu_share_arb.sv | 112 +++++++++++
 tb/tb_alu_share_arb.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice:
// opcodes, datapath width and sequencer state encoding.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_PA  = 3'b101;
    localparam logic [2:0] OP_PB  = 3'b110;
    localparam logic [2:0] OP_CLR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU; carry_flag is carry-out on add
// and borrow on sub, zero otherwise.
module alu_4bit
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       op,
    output logic [ALU_W-1:0] result,
    output logic             carry_flag
);

    logic [ALU_W:0] sum;
    logic [ALU_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result     = '0;
        carry_flag = 1'b0;
        unique case (op)
            OP_ADD: begin
                result     = sum[ALU_W-1:0];
                carry_flag = sum[ALU_W];
            end
            OP_SUB: begin
                result     = diff[ALU_W-1:0];
                carry_flag = diff[ALU_W];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_PA:  result = a;
            OP_PB:  result = b;
            OP_CLR: result = '0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one alu_4bit between
// two valid/ready clients, with per-client completion counters.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [7:0]         req_a,
    input  logic [7:0]         req_b,
    input  logic [5:0]         req_op,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [3:0]         rsp_result,
    output logic               rsp_carry,
    output logic               busy,
    output logic [2*CNT_W-1:0] done_cnt
);

    state_e                    state_q;
    logic                      rr_q;
    logic                      gnt_q;
    logic [ALU_W-1:0]          op_a_q;
    logic [ALU_W-1:0]          op_b_q;
    logic [2:0]                op_code_q;
    logic [1:0]                rsp_valid_q;
    logic [ALU_W-1:0]          rsp_result_q;
    logic                      rsp_carry_q;
    logic [1:0][CNT_W-1:0]     cnt_q;

    logic                      any_v;
    logic                      g;
    logic [ALU_W-1:0]          sel_a;
    logic [ALU_W-1:0]          sel_b;
    logic [2:0]                sel_op;
    logic [ALU_W-1:0]          alu_res;
    logic                      alu_cy;

    // Ties go to rr_q; a lone requester always wins.
    assign any_v  = |req_valid;
    assign g      = (&req_valid) ? rr_q : req_valid[1];
    assign sel_a  = g ? req_a[7:4] : req_a[3:0];
    assign sel_b  = g ? req_b[7:4] : req_b[3:0];
    assign sel_op = g ? req_op[5:3] : req_op[2:0];

    always_comb begin
        req_ready = 2'b00;
        if (state_q == ST_IDLE && any_v) begin
            req_ready[g] = 1'b1;
        end
    end

    alu_4bit u_alu (
        .a          (op_a_q),
        .b          (op_b_q),
        .op         (op_code_q),
        .result     (alu_res),
        .carry_flag (alu_cy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            gnt_q        <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_code_q    <= '0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_v) begin
                        op_a_q    <= sel_a;
                        op_b_q    <= sel_b;
                        op_code_q <= sel_op;
                        gnt_q     <= g;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_q <= alu_res;
                    rsp_carry_q  <= is_arith(op_code_q) & alu_cy;
                    rsp_valid_q  <= gnt_q ? 2'b10 : 2'b01;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[gnt_q]) begin
                        cnt_q[gnt_q] <= cnt_q[gnt_q] + CNT_W'(1);
                        rr_q         <= ~gnt_q;
                        rsp_valid_q  <= 2'b00;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_carry  = rsp_carry_q;
    assign busy       = (state_q != ST_IDLE);
    assign done_cnt   = cnt_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench: directed table, corner sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_share_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [5:0] req_op;
    logic [1:0] rsp_ready;
    logic [1:0] req_ready,  req_ready2;
    logic [1:0] rsp_valid,  rsp_valid2;
    logic [3:0] rsp_result, rsp_result2;
    logic       rsp_carry,  rsp_carry2;
    logic       busy,       busy2;
    logic [15:0] done_cnt;
    logic [3:0]  done_cnt2;

    always #5 clk = ~clk;

    alu_share_arb #(.CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .busy(busy), .done_cnt(done_cnt)
    );

    alu_share_arb #(.CNT_W(2)) u_w2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready2),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result2), .rsp_carry(rsp_carry2),
        .busy(busy2), .done_cnt(done_cnt2)
    );

    typedef struct {
        logic       c;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] r;
        logic       cy;
    } vec_t;

    vec_t tbl[10];

    int         nvec = 0;
    int         nerr = 0;
    int         rr_m;
    int         cnt_m[2];
    logic [1:0] vld;
    logic [3:0] pa[2];
    logic [3:0] pb[2];
    logic [2:0] pop[2];

    function automatic logic [4:0] alu_ref(input logic [3:0] a,
                                           input logic [3:0] b,
                                           input logic [2:0] op);
        int x = int'(a);
        int y = int'(b);
        int s;
        case (op)
            3'd0: begin s = x + y; return {s > 15, 4'(s % 16)}; end
            3'd1: begin s = (x - y + 16) % 16; return {x < y, 4'(s)}; end
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, a};
            3'd6: return {1'b0, b};
            default: return 5'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive();
        req_valid = vld;
        req_a     = {pa[1], pa[0]};
        req_b     = {pb[1], pb[0]};
        req_op    = {pop[1], pop[0]};
    endtask

    task automatic chk_cnt();
        chk("done_cnt0", 32'(done_cnt[7:0]),  32'(cnt_m[0] % 256));
        chk("done_cnt1", 32'(done_cnt[15:8]), 32'(cnt_m[1] % 256));
        chk("w2_cnt0",   32'(done_cnt2[1:0]), 32'(cnt_m[0] % 4));
        chk("w2_cnt1",   32'(done_cnt2[3:2]), 32'(cnt_m[1] % 4));
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_busy",      32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_result",    32'(rsp_result), 0);
        chk("rst_carry",     32'(rsp_carry), 0);
        chk("rst_done_cnt",  32'(done_cnt), 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        vld       = 2'b00;
        rsp_ready = 2'b00;
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        rr_m     = 0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
    endtask

    // Called at a negedge with the DUT idle and vld nonzero.
    task automatic step(input int dly, output logic [3:0] r_o,
                        output logic c_o, output int g_o);
        int         g;
        logic [1:0] oh;
        logic [4:0] e;
        drive();
        #1;
        g  = (vld == 2'b11) ? rr_m : (vld[1] ? 1 : 0);
        oh = 2'(1 << g);
        e  = alu_ref(pa[g], pb[g], pop[g]);
        chk("req_ready", 32'(req_ready), 32'(oh));
        chk("busy_idle", 32'(busy), 0);
        @(posedge clk);
        #1;
        vld[g] = 1'b0;
        drive();
        @(negedge clk);
        chk("exec_busy",      32'(busy), 1);
        chk("exec_req_ready", 32'(req_ready), 0);
        chk("exec_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("rsp_valid",  32'(rsp_valid), 32'(oh));
        chk("rsp_result", 32'(rsp_result), 32'(e[3:0]));
        chk("rsp_carry",  32'(rsp_carry), 32'(e[4]));
        r_o = rsp_result;
        c_o = rsp_carry;
        for (int k = 0; k < dly; k++) begin
            rsp_ready = ~oh;
            @(negedge clk);
            chk("hold_valid",     32'(rsp_valid), 32'(oh));
            chk("hold_result",    32'(rsp_result), 32'(e[3:0]));
            chk("hold_carry",     32'(rsp_carry), 32'(e[4]));
            chk("hold_req_ready", 32'(req_ready), 0);
            chk("hold_busy",      32'(busy), 1);
        end
        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = 2'b00;
        cnt_m[g]++;
        rr_m = 1 - g;
        chk("post_rsp_valid", 32'(rsp_valid), 0);
        chk("post_busy",      32'(busy), 0);
        chk_cnt();
        g_o = g;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        logic       c;
        int         g;

        tbl[0] = '{1'b0, 4'd5,  4'd3,  3'd0, 4'd8,  1'b0};
        tbl[1] = '{1'b1, 4'd9,  4'd8,  3'd0, 4'd1,  1'b1};
        tbl[2] = '{1'b1, 4'd5,  4'd3,  3'd2, 4'd1,  1'b0};
        tbl[3] = '{1'b0, 4'd5,  4'd3,  3'd1, 4'd2,  1'b0};
        tbl[4] = '{1'b1, 4'd3,  4'd5,  3'd1, 4'd14, 1'b1};
        tbl[5] = '{1'b0, 4'd5,  4'd3,  3'd3, 4'd7,  1'b0};
        tbl[6] = '{1'b1, 4'd12, 4'd10, 3'd4, 4'd6,  1'b0};
        tbl[7] = '{1'b0, 4'd15, 4'd15, 3'd5, 4'd15, 1'b0};
        tbl[8] = '{1'b1, 4'd15, 4'd9,  3'd6, 4'd9,  1'b0};
        tbl[9] = '{1'b0, 4'd15, 4'd15, 3'd7, 4'd0,  1'b0};

        for (int i = 0; i < 2; i++) begin
            pa[i] = '0; pb[i] = '0; pop[i] = '0;
        end
        do_reset();
        #1;
        chk_reset_vals();

        for (int i = 0; i < 10; i++) begin
            vld = tbl[i].c ? 2'b10 : 2'b01;
            pa[tbl[i].c]  = tbl[i].a;
            pb[tbl[i].c]  = tbl[i].b;
            pop[tbl[i].c] = tbl[i].op;
            step(0, r, c, g);
            chk("tbl_grant",  32'(g), 32'(tbl[i].c));
            chk("tbl_result", 32'(r), 32'(tbl[i].r));
            chk("tbl_carry",  32'(c), 32'(tbl[i].cy));
        end

        // Tie straight after reset: client 0 first.
        do_reset();
        pa[0] = 4'd5; pb[0] = 4'd3; pop[0] = 3'd2;
        pa[1] = 4'd5; pb[1] = 4'd3; pop[1] = 3'd4;
        vld = 2'b11;
        step(0, r, c, g);
        chk("tie_first_g", 32'(g), 0);
        chk("tie_first_r", 32'(r), 32'd1);
        step(0, r, c, g);
        chk("tie_second_g", 32'(g), 1);
        chk("tie_second_r", 32'(r), 32'd6);

        // Continuous requests from both clients alternate.
        do_reset();
        pa[0] = 4'hA; pb[0] = 4'h3; pop[0] = 3'd5;
        pa[1] = 4'h7; pb[1] = 4'h2; pop[1] = 3'd7;
        vld = 2'b11;
        for (int i = 0; i < 10; i++) begin
            step(0, r, c, g);
            chk("alt_grant", 32'(g), 32'(i % 2));
            chk("alt_result", 32'(r), (i % 2) ? 32'd0 : 32'hA);
            vld[g] = 1'b1;
        end
        chk("alt_cnt0", 32'(done_cnt[7:0]), 32'd5);
        chk("alt_cnt1", 32'(done_cnt[15:8]), 32'd5);

        // Backpressure with a stray rsp_ready on the other client.
        vld = 2'b01;
        pa[0] = 4'd9; pb[0] = 4'd9; pop[0] = 3'd0;
        step(5, r, c, g);
        chk("bp_result", 32'(r), 32'd2);
        chk("bp_carry",  32'(c), 32'd1);

        // Reset while the command is in EXEC.
        vld = 2'b01;
        pa[0] = 4'd7; pb[0] = 4'd6; pop[0] = 3'd0;
        drive();
        @(posedge clk);
        #1;
        vld = 2'b00;
        drive();
        @(negedge clk);
        chk("mid_exec_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        rr_m = 0; cnt_m[0] = 0; cnt_m[1] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'(rsp_valid), 0);
            chk("mid_idle",   32'(busy), 0);
        end
        chk_cnt();

        // Narrow counter wraps after four completions.
        vld = 2'b00;
        for (int i = 0; i < 4; i++) begin
            vld = 2'b01;
            pa[0] = 4'(i); pb[0] = 4'd1; pop[0] = 3'd0;
            step(0, r, c, g);
        end
        chk("w2_wrap", 32'(done_cnt2[1:0]), 0);
        chk("w8_four", 32'(done_cnt[7:0]), 32'd4);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!vld[k] && $urandom_range(0, 1) == 1) begin
                    vld[k] = 1'b1;
                    pa[k]  = 4'($urandom);
                    pb[k]  = 4'($urandom);
                    pop[k] = 3'($urandom);
                end
            end
            if (vld == 2'b00) begin
                drive();
                #1;
                chk("idle_req_ready", 32'(req_ready), 0);
                @(negedge clk);
            end else begin
                step(int'($urandom_range(0, 2)), r, c, g);
            end
        end

        // Long tie stream so both 8-bit counters wrap.
        do_reset();
        vld = 2'b11;
        for (int i = 0; i < 520; i++) begin
            step(0, r, c, g);
            vld[g] = 1'b1;
            pa[g]  = 4'($urandom);
            pb[g]  = 4'($urandom);
            pop[g] = 3'($urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
